// File: rtl/serial_to_block.sv
// rtl/serial_to_block.sv - packs serial W-bit samples into 5-sample blocks for block_filter
// Ping-pong banks: one bank fills from the serial side while the other waits for the consumer.
module serial_to_block #(
   parameter int W     = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [W-1:0]     s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             flush,
   output logic [W-1:0]     out0,
   output logic [W-1:0]     out_1,
   output logic [W-1:0]     out_2,
   output logic [W-1:0]     out_3,
   output logic [W-1:0]     out_4,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic [CNT_W-1:0] blk_count
);

   logic [W-1:0] bank [2][5];
   logic [1:0]   full;
   logic [2:0]   wr_idx;
   logic         wb;
   logic         rb;
   logic         accept;
   logic         drain;
   logic         close;

   // Padding finishes in a single edge, so the write side only stalls on a full bank.
   assign s_ready = !full[wb];
   assign accept  = s_valid && s_ready;
   assign drain   = full[rb] && blk_ready;
   assign close   = (accept && (wr_idx == 3'd4)) ||
                    (flush && (accept || (wr_idx != 3'd0)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 5; k++) begin
               bank[b][k] <= '0;
            end
         end
         full      <= '0;
         wr_idx    <= '0;
         wb        <= 1'b0;
         rb        <= 1'b0;
         blk_count <= '0;
      end else begin
         // An accepted sample takes its slot first; flush zero-fills every slot after it.
         for (int k = 0; k < 5; k++) begin
            if (accept && (wr_idx == 3'(k))) begin
               bank[wb][k] <= s_data;
            end else if (close && (3'(k) >= wr_idx)) begin
               bank[wb][k] <= '0;
            end
         end

         if (close) begin
            full[wb] <= 1'b1;
            wb       <= ~wb;
            wr_idx   <= '0;
         end else if (accept) begin
            wr_idx <= wr_idx + 3'd1;
         end

         // A full bank is never written, so close and drain always target different banks.
         if (drain) begin
            full[rb]  <= 1'b0;
            rb        <= ~rb;
            blk_count <= blk_count + CNT_W'(1);
         end
      end
   end

   assign blk_valid = full[rb];
   assign out_4     = bank[rb][0];
   assign out_3     = bank[rb][1];
   assign out_2     = bank[rb][2];
   assign out_1     = bank[rb][3];
   assign out0      = bank[rb][4];

endmodule

// File: tb/tb_serial_to_block.sv
// tb/tb_serial_to_block.sv - directed self-checking bench for serial_to_block
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serial_to_block;

   localparam int W     = 16;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [W-1:0]     s_data;
   logic             s_valid;
   logic             s_ready;
   logic             flush;
   logic [W-1:0]     out0;
   logic [W-1:0]     out_1;
   logic [W-1:0]     out_2;
   logic [W-1:0]     out_3;
   logic [W-1:0]     out_4;
   logic             blk_valid;
   logic             blk_ready;
   logic [CNT_W-1:0] blk_count;

   int n_tests = 0;
   int n_fail  = 0;

   serial_to_block #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .flush     (flush),
      .out0      (out0),
      .out_1     (out_1),
      .out_2     (out_2),
      .out_3     (out_3),
      .out_4     (out_4),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_count (blk_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_block(input string tag, input logic [W-1:0] e4, input logic [W-1:0] e3,
                              input logic [W-1:0] e2, input logic [W-1:0] e1, input logic [W-1:0] e0);
      check({tag, "_valid"}, 32'(blk_valid), 32'd1);
      check({tag, "_out_4"}, 32'(out_4), 32'(e4));
      check({tag, "_out_3"}, 32'(out_3), 32'(e3));
      check({tag, "_out_2"}, 32'(out_2), 32'(e2));
      check({tag, "_out_1"}, 32'(out_1), 32'(e1));
      check({tag, "_out0"},  32'(out0),  32'(e0));
   endtask

   task automatic send(input logic [W-1:0] d);
      s_valid = 1'b1;
      s_data  = d;
      step();
      s_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      s_data    = '0;
      s_valid   = 1'b0;
      flush     = 1'b0;
      blk_ready = 1'b1;
      step();
      step();
      check("rst_out0", 32'(out0), 32'd0);
      check("rst_out_1", 32'(out_1), 32'd0);
      check("rst_out_2", 32'(out_2), 32'd0);
      check("rst_out_3", 32'(out_3), 32'd0);
      check("rst_out_4", 32'(out_4), 32'd0);
      check("rst_blk_valid", 32'(blk_valid), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_blk_count", 32'(blk_count), 32'd0);
      reset = 1'b0;

      // Full-rate ramp with the consumer always ready
      for (int i = 1; i <= 10; i++) begin
         check("ramp_s_ready", 32'(s_ready), 32'd1);
         s_valid = 1'b1;
         s_data  = W'(i);
         step();
         if (i == 5)  check_block("ramp_b1", 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
         if (i == 10) check_block("ramp_b2", 16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A);
         if (i < 5)   check("ramp_early_valid", 32'(blk_valid), 32'd0);
      end
      s_valid = 1'b0;
      step();
      check("ramp_count", 32'(blk_count), 32'd2);
      check("ramp_idle_valid", 32'(blk_valid), 32'd0);

      // Backpressure: both banks fill, input stalls
      blk_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("bp_s_ready", 32'(s_ready), 32'd1);
         s_valid = 1'b1;
         s_data  = 16'h0100 + W'(i);
         step();
      end
      check("bp_stall", 32'(s_ready), 32'd0);
      s_data = 16'h010A;
      for (int i = 0; i < 20; i++) begin
         check("bp_hold_valid", 32'(blk_valid), 32'd1);
         check("bp_hold_out_4", 32'(out_4), 32'h0100);
         check("bp_hold_out0", 32'(out0), 32'h0104);
         check("bp_hold_stall", 32'(s_ready), 32'd0);
         step();
      end
      blk_ready = 1'b1;
      step();
      blk_ready = 1'b0;
      check_block("bp_b2", 16'h0105, 16'h0106, 16'h0107, 16'h0108, 16'h0109);
      check("bp_ready_back", 32'(s_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         s_data = 16'h010A + W'(i);
         step();
      end
      s_valid = 1'b0;
      check_block("bp_b2_held", 16'h0105, 16'h0106, 16'h0107, 16'h0108, 16'h0109);
      blk_ready = 1'b1;
      step();
      check_block("bp_b3", 16'h010A, 16'h010B, 16'h010C, 16'h010D, 16'h010E);
      step();
      check("bp_drained", 32'(blk_valid), 32'd0);
      check("bp_count", 32'(blk_count), 32'd5);

      // Flush of a two-sample partial block
      send(16'hAAAA);
      send(16'hBBBB);
      check("fl_no_valid", 32'(blk_valid), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_block("fl_blk", 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 16'h0000);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fl_empty_valid", 32'(blk_valid), 32'd0);
      step();
      check("fl_empty_valid2", 32'(blk_valid), 32'd0);
      check("fl_count", 32'(blk_count), 32'd6);

      // Flush on the same edge as the fourth sample
      send(16'h0001);
      send(16'h0002);
      send(16'h0003);
      s_valid = 1'b1;
      s_data  = 16'h0004;
      flush   = 1'b1;
      step();
      s_valid = 1'b0;
      flush   = 1'b0;
      check_block("fls_blk", 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0000);
      step();
      check("fls_count", 32'(blk_count), 32'd7);

      // Reset in the middle of a block discards it
      send(16'h0021);
      send(16'h0022);
      send(16'h0023);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_count", 32'(blk_count), 32'd0);
      check("mid_rst_valid", 32'(blk_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         send(16'h0011 + W'(i));
         if (i < 4) check("mid_rst_early", 32'(blk_valid), 32'd0);
      end
      check_block("mid_rst_blk", 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015);
      step();
      check("mid_rst_count1", 32'(blk_count), 32'd1);
      check("mid_rst_idle", 32'(blk_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
